spi_slave_if: RTL
=================

// Module: spi_slave_if
// PURPOSE
//  SPI slave front-end (mode 0, MSB first) feeding the dual-port RAM command interface.
//  Oversamples SCLK/SS_n/MOSI on the system clock, deserialises 10-bit command words into
//  rx_data/rx_valid, and serialises the RAM's 8-bit read data onto MISO.
//  Sits between the SPI pins and the RAM; the only SPI-facing block in the design.
// PARAMETERS
//  RX_WIDTH     10  command word width (bits [9:8] = opcode, [7:0] = addr/data)
//  TX_WIDTH     8   read-data width shifted out on MISO
//  SYNC_STAGES  2   synchroniser depth on SCLK, SS_n and MOSI (>=2)
// PORTS
//  CLK       in   1         system clock; all logic on posedge
//  rst       in   1         synchronous, active-high reset
//  SCLK      in   1         SPI clock, asynchronous to CLK
//  SS_n      in   1         SPI slave select, active low
//  MOSI      in   1         SPI master-out data
//  MISO      out  1         SPI master-in data
//  rx_data   out  RX_WIDTH  received command word, to RAM din
//  rx_valid  out  1         1-cycle strobe: rx_data holds a new word
//  tx_data   in   TX_WIDTH  RAM read data (RAM dout)
//  tx_valid  in   1         RAM read data valid
//  frame_err out  1         1-cycle strobe: frame aborted before completion
// BEHAVIOUR
//  Reset: MISO=0, rx_data=0, rx_valid=0, frame_err=0, bit count=0, state=IDLE; synchronisers cleared
//    (SS_n sync chain resets to 1). Reset overrides any frame in progress; no strobes result from it.
//  Inputs pass through SYNC_STAGES flops plus one history flop; rise/fall of SCLK and SS_n are
//    detected from the synchronised signals. SCLK high and low phases must each be >= 4 CLK periods.
//  MOSI is sampled on the synchronised SCLK rising edge; MISO changes only on falling edges or on load.
//  FSM:
//   IDLE    : MISO=0. SS_n fall -> RX, bit count=0.
//   RX      : each SCLK rise shifts MOSI into the shift register, MSB first. On the 10th bit:
//             rx_data<=shift word, rx_valid=1 for exactly the next cycle; if word[9:8]==2'b11 -> TX_WAIT,
//             else -> DONE. rx_data holds its value until the next completed word.
//   TX_WAIT : wait for tx_valid. On tx_valid: latch tx_data, MISO<=tx_data[7] next cycle, -> TX.
//             SCLK edges in this state are ignored (master must allow >= 4 CLK after the 10th rise).
//   TX      : each SCLK fall drives the next bit (6..0). After the 8th SCLK rise -> DONE; MISO holds last bit.
//   DONE    : ignore SCLK; MISO holds. SS_n rise -> IDLE.
//  SS_n rise in RX (<10 bits), TX_WAIT or TX: frame_err=1 for one cycle, no rx_valid, -> IDLE, MISO=0.
//  SS_n rise in the same cycle as the 10th SCLK rise: the word completes (rx_valid=1), no frame_err, -> IDLE.
//  SS_n rise in DONE or IDLE: no frame_err. tx_valid outside TX_WAIT is ignored.
//  SCLK edges while SS_n is high are ignored. Back-to-back frames need SS_n high >= 4 CLK.
//  Latency: rx_valid rises 1 CLK after the CLK that registers the synchronised 10th SCLK rise.
// TESTING
//  1. Frame 10'b00_1010_0101 -> single rx_valid pulse, rx_data=10'h0A5, state DONE, MISO stays 0.
//  2. Frame 10'b11_0000_0000, RAM returns tx_valid with tx_data=8'h3C 1 CLK after rx_valid ->
//     MISO sampled on 8 SCLK rises = 0,0,1,1,1,1,0,0.
//  3. SS_n rise after 5 SCLK rises -> frame_err pulse, no rx_valid, rx_data unchanged, next frame decodes correctly.
//  4. rst asserted mid-TX (after 3 bits out) -> MISO=0, no strobes, IDLE; next frame 10'h1FF -> rx_data=10'h1FF.
//  5. tx_valid pulsed during RX and IDLE -> ignored; MISO stays 0; rx_valid still fires once at bit 10.
//  6. Back-to-back frames 10'h012, 10'h155 (SS_n high 4 CLK) -> two rx_valid pulses, values in order.

Source files
------------

// File: rtl/spi_slave_if_if.sv
// Signal bundle between the SPI pins / RAM command port and the SPI slave front-end.
// The slave modport is the view taken by spi_slave_if; the master view drives the pins and the RAM side.
`timescale 1ns/1ps
interface spi_slave_if_if #(
  parameter int RX_WIDTH = 10,
  parameter int TX_WIDTH = 8
);
  logic                SCLK;
  logic                SS_n;
  logic                MOSI;
  logic                MISO;
  logic [RX_WIDTH-1:0] rx_data;
  logic                rx_valid;
  logic [TX_WIDTH-1:0] tx_data;
  logic                tx_valid;
  logic                frame_err;

  modport slave (
    input  SCLK, SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid, frame_err
  );

  modport master (
    output SCLK, SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid, frame_err
  );
endinterface

// File: rtl/spi_slave_if.sv
// SPI mode-0 slave front-end: oversamples the SPI pins on CLK, deserialises 10-bit command
// words for the RAM and shifts the RAM's 8-bit read data back out on MISO, MSB first.
`timescale 1ns/1ps
module spi_slave_if #(
  parameter int RX_WIDTH    = 10,
  parameter int TX_WIDTH    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic           CLK,
  input  logic           rst,
  spi_slave_if_if.slave  bus
);

  localparam int CNT_W = $clog2(RX_WIDTH + 1);
  localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(RX_WIDTH - 1);
  localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(TX_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    RX,
    TX_WAIT,
    TX,
    DONE
  } state_t;

  state_t state, next_state;

  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic                   sclk_hist, ss_hist;
  logic                   sclk_s, ss_s, mosi_s;
  logic                   sclk_rise, sclk_fall, ss_rise, ss_fall;

  logic [CNT_W-1:0]       bit_cnt;
  logic [RX_WIDTH-2:0]    rx_shift;
  logic [RX_WIDTH-1:0]    rx_word;
  logic [TX_WIDTH-1:0]    tx_shift;
  logic                   miso_q;
  logic [RX_WIDTH-1:0]    rx_data_q;
  logic                   rx_valid_q;
  logic                   frame_err_q;

  logic shift_en, word_done, err, load_tx, drive_bit, clr_miso, cnt_clr, cnt_inc;

  // The SS_n chain resets high so a reset never looks like the start of a frame.
  always_ff @(posedge CLK) begin
    if (rst) begin
      sclk_sync <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sclk_hist <= 1'b0;
      ss_hist   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.SCLK};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], bus.SS_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.MOSI};
      sclk_hist <= sclk_sync[SYNC_STAGES-1];
      ss_hist   <= ss_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist;
  assign sclk_fall = ~sclk_s & sclk_hist;
  assign ss_rise   = ss_s & ~ss_hist;
  assign ss_fall   = ~ss_s & ss_hist;
  assign rx_word   = {rx_shift, mosi_s};

  always_ff @(posedge CLK) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // In TX the bit counter counts master rises; a fall only advances MISO once the master has
  // sampled the current bit, so the fall trailing the command's 10th rise never skips bit 7.
  always_comb begin
    next_state = state;
    shift_en   = 1'b0;
    word_done  = 1'b0;
    err        = 1'b0;
    load_tx    = 1'b0;
    drive_bit  = 1'b0;
    clr_miso   = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall) begin
          next_state = RX;
          cnt_clr    = 1'b1;
        end
      end
      RX: begin
        if (sclk_rise && bit_cnt == RX_LAST) begin
          word_done = 1'b1;
          if (ss_rise) begin
            next_state = IDLE;
            clr_miso   = 1'b1;
          end else if (rx_word[RX_WIDTH-1 -: 2] == 2'b11) begin
            next_state = TX_WAIT;
          end else begin
            next_state = DONE;
          end
        end else if (ss_rise) begin
          err        = 1'b1;
          clr_miso   = 1'b1;
          next_state = IDLE;
        end else if (sclk_rise) begin
          shift_en = 1'b1;
          cnt_inc  = 1'b1;
        end
      end
      TX_WAIT: begin
        if (ss_rise) begin
          err        = 1'b1;
          clr_miso   = 1'b1;
          next_state = IDLE;
        end else if (bus.tx_valid) begin
          load_tx    = 1'b1;
          cnt_clr    = 1'b1;
          next_state = TX;
        end
      end
      TX: begin
        if (ss_rise) begin
          err        = 1'b1;
          clr_miso   = 1'b1;
          next_state = IDLE;
        end else if (sclk_rise) begin
          cnt_inc = 1'b1;
          if (bit_cnt == TX_LAST) next_state = DONE;
        end else if (sclk_fall && bit_cnt != '0) begin
          drive_bit = 1'b1;
        end
      end
      DONE: begin
        if (ss_rise) begin
          clr_miso   = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      miso_q      <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_valid_q  <= word_done;
      frame_err_q <= err;
      if (cnt_clr)      bit_cnt <= '0;
      else if (cnt_inc) bit_cnt <= bit_cnt + CNT_W'(1);
      if (shift_en)  rx_shift  <= rx_word[RX_WIDTH-2:0];
      if (word_done) rx_data_q <= rx_word;
      if (load_tx) begin
        miso_q   <= bus.tx_data[TX_WIDTH-1];
        tx_shift <= {bus.tx_data[TX_WIDTH-2:0], 1'b0};
      end else if (drive_bit) begin
        miso_q   <= tx_shift[TX_WIDTH-1];
        tx_shift <= {tx_shift[TX_WIDTH-2:0], 1'b0};
      end else if (clr_miso) begin
        miso_q <= 1'b0;
      end
    end
  end

  assign bus.MISO      = miso_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;

endmodule
